// File: rtl/pci_master_cmd_seq_if.sv
// Host-side command/write-data/read-return handshakes plus the PCI initiator-control and bus-observation signals.
// master = the sequencer; slave = host and bus environment.
interface pci_master_cmd_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_len;
    logic [3:0]  cmd_be;
    logic        wd_valid;
    logic        wd_ready;
    logic [31:0] wd_data;
    logic        force_req;
    logic        rw;
    logic [31:0] contactAddress;
    logic [31:0] data;
    logic [3:0]  BE;
    logic        grant;
    logic        iframe;
    logic        iready;
    logic        tready;
    logic        devsel;
    logic [31:0] AD;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        err;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_len, cmd_be,
        input  wd_valid, wd_data,
        input  grant, iframe, iready, tready, devsel, AD,
        output cmd_ready, wd_ready,
        output force_req, rw, contactAddress, data, BE,
        output rd_valid, rd_data, done, err
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_len, cmd_be,
        output wd_valid, wd_data,
        output grant, iframe, iready, tready, devsel, AD,
        input  cmd_ready, wd_ready,
        input  force_req, rw, contactAddress, data, BE,
        input  rd_valid, rd_data, done, err
    );
endinterface

// File: rtl/pci_master_cmd_seq.sv
// PCI initiator command sequencer: queues host commands and write words, drives the device request/control
// inputs and counts data phases. Optional master-abort timeout in ADDR via PCI_SEQ_TIMEOUT_EN.
module pci_master_cmd_seq #(
    parameter int CMD_DEPTH   = 4,
    parameter int WDATA_DEPTH = 8,
    parameter int TIMEOUT     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pci_master_cmd_seq_if.master bus
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int WAW = $clog2(WDATA_DEPTH);

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [3:0]  be;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, DONE} state_t;

    cmd_t         cmd_mem_q [CMD_DEPTH];
    logic [31:0]  wd_mem_q  [WDATA_DEPTH];
    logic [CAW:0] cmd_wptr_q, cmd_rptr_q;
    logic [WAW:0] wd_wptr_q, wd_rptr_q;
    logic [WAW:0] wd_count, wd_need, wd_pop_n;
    logic         cmd_full, cmd_empty, wd_full;
    logic         cmd_push, wd_push, cmd_pop;
    logic [WAW-1:0] wd_nxt_idx;
    cmd_t         cmd_in, cmd_head;
    logic [31:0]  wd_head, wd_nxt;
    logic         launch_ok, beat;

    state_t      state_q, state_d;
    logic        force_req_q, force_req_d;
    logic        rw_q, rw_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        done_q, done_d;

`ifdef PCI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
`endif

    // Full is pointer-based only, so a same-cycle pop never reopens the FIFO.
    assign cmd_full  = (cmd_wptr_q[CAW] != cmd_rptr_q[CAW]) &&
                       (cmd_wptr_q[CAW-1:0] == cmd_rptr_q[CAW-1:0]);
    assign cmd_empty = (cmd_wptr_q == cmd_rptr_q);
    assign wd_full   = (wd_wptr_q[WAW] != wd_rptr_q[WAW]) &&
                       (wd_wptr_q[WAW-1:0] == wd_rptr_q[WAW-1:0]);
    assign wd_count  = wd_wptr_q - wd_rptr_q;

    assign cmd_push = bus.cmd_valid && !cmd_full;
    assign wd_push  = bus.wd_valid && !wd_full;

    assign cmd_in     = '{rw: bus.cmd_rw, addr: bus.cmd_addr, len: bus.cmd_len, be: bus.cmd_be};
    assign cmd_head   = cmd_mem_q[cmd_rptr_q[CAW-1:0]];
    assign wd_head    = wd_mem_q[wd_rptr_q[WAW-1:0]];
    assign wd_nxt_idx = wd_rptr_q[WAW-1:0] + WAW'(1);
    assign wd_nxt     = wd_mem_q[wd_nxt_idx];
    assign wd_need    = (WAW+1)'(cmd_head.len) + (WAW+1)'(1);

    // A write only launches once its whole burst is buffered, so DATA never starves.
    assign launch_ok = !cmd_empty && (!cmd_head.rw || (wd_count >= wd_need));
    assign beat      = !bus.iready && !bus.tready;

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wptr_q[CAW-1:0]] <= cmd_in;
        if (wd_push)  wd_mem_q[wd_wptr_q[WAW-1:0]]   <= bus.wd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wptr_q <= '0;
            cmd_rptr_q <= '0;
            wd_wptr_q  <= '0;
            wd_rptr_q  <= '0;
        end else begin
            if (cmd_push) cmd_wptr_q <= cmd_wptr_q + (CAW+1)'(1);
            if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + (CAW+1)'(1);
            if (wd_push)  wd_wptr_q  <= wd_wptr_q + (WAW+1)'(1);
            wd_rptr_q <= wd_rptr_q + wd_pop_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            force_req_q <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
`ifdef PCI_SEQ_TIMEOUT_EN
            tcnt_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            force_req_q <= force_req_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
`ifdef PCI_SEQ_TIMEOUT_EN
            tcnt_q      <= tcnt_d;
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        force_req_d = force_req_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        done_d      = 1'b0;
        cmd_pop     = 1'b0;
        wd_pop_n    = '0;
`ifdef PCI_SEQ_TIMEOUT_EN
        tcnt_d      = tcnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            // The command pops on the completing edge, so DONE already sees the next head and
            // can relaunch directly, keeping force_req low for exactly one cycle.
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (launch_ok) begin
                    state_d     = REQ;
                    force_req_d = 1'b1;
                    rw_d        = cmd_head.rw;
                    addr_d      = cmd_head.addr;
                    be_d        = cmd_head.be;
                    len_d       = cmd_head.len;
                    if (cmd_head.rw) data_d = wd_head;
                end
            end
            REQ: begin
                if (!bus.grant && bus.iframe && bus.iready) begin
                    state_d = ADDR;
`ifdef PCI_SEQ_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            ADDR: begin
                if (!bus.devsel && !bus.tready) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
`ifdef PCI_SEQ_TIMEOUT_EN
                else if (bus.devsel) begin
                    if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        state_d     = DONE;
                        force_req_d = 1'b0;
                        done_d      = 1'b1;
                        err_d       = 1'b1;
                        cmd_pop     = 1'b1;
                        if (rw_q) wd_pop_n = (WAW+1)'(len_q) + (WAW+1)'(1);
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
`endif
            end
            DATA: begin
                if (beat) begin
                    if (rw_q) begin
                        wd_pop_n = (WAW+1)'(1);
                        if (cnt_q != len_q) data_d = wd_nxt;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = bus.AD;
                    end
                    if (cnt_q == len_q) begin
                        state_d     = DONE;
                        force_req_d = 1'b0;
                        done_d      = 1'b1;
                        cmd_pop     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready      = !cmd_full;
    assign bus.wd_ready       = !wd_full;
    assign bus.force_req      = force_req_q;
    assign bus.rw             = rw_q;
    assign bus.contactAddress = addr_q;
    assign bus.data           = data_q;
    assign bus.BE             = be_q;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.rd_data        = rd_data_q;
    assign bus.done           = done_q;
`ifdef PCI_SEQ_TIMEOUT_EN
    assign bus.err            = err_q;
`else
    assign bus.err            = 1'b0;
`endif
endmodule

// File: tb/tb_pci_master_cmd_seq.sv
// Directed bench for pci_master_cmd_seq: write, burst read, write gating, full/back-to-back, abort, reset.
module tb_pci_master_cmd_seq;
    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    pci_master_cmd_seq_if bus_if();

    pci_master_cmd_seq #(.CMD_DEPTH(4), .WDATA_DEPTH(8), .TIMEOUT(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        bus_if.grant  = 1'b1;
        bus_if.iframe = 1'b1;
        bus_if.iready = 1'b1;
        bus_if.tready = 1'b1;
        bus_if.devsel = 1'b1;
    endtask

    // Target claims and both sides go ready; next edge enters DATA.
    task automatic bus_claim;
        bus_if.devsel = 1'b0;
        bus_if.tready = 1'b0;
        bus_if.iready = 1'b0;
        bus_if.iframe = 1'b0;
    endtask

    task automatic push_wd(input logic [31:0] w);
        bus_if.wd_valid = 1'b1;
        bus_if.wd_data  = w;
        tick();
        bus_if.wd_valid = 1'b0;
    endtask

    task automatic push_cmd(input logic r, input logic [31:0] a, input logic [2:0] l, input logic [3:0] b);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_rw    = r;
        bus_if.cmd_addr  = a;
        bus_if.cmd_len   = l;
        bus_if.cmd_be    = b;
        tick();
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_req(output int cyc);
        cyc = 0;
        while (!bus_if.force_req && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        vec_cnt++;
        if ({bus_if.cmd_ready, bus_if.wd_ready, bus_if.force_req, bus_if.rw, bus_if.contactAddress,
             bus_if.data, bus_if.BE, bus_if.rd_valid, bus_if.rd_data, bus_if.done, bus_if.err}
            !== {1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset_values: rdy=%b wrdy=%b req=%b rw=%b addr=%h data=%h be=%h rv=%b rd=%h done=%b err=%b, want 1 1 0 0 0 0 0 0 0 0 0",
                     bus_if.cmd_ready, bus_if.wd_ready, bus_if.force_req, bus_if.rw, bus_if.contactAddress,
                     bus_if.data, bus_if.BE, bus_if.rd_valid, bus_if.rd_data, bus_if.done, bus_if.err);
        end
        rst_n = 1'b1;
        tick();
        vec_cnt++;
        if (bus_if.force_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_idle: force_req=%b want 0", bus_if.force_req);
        end
    endtask

    task automatic test_single_write;
        push_wd(32'd255);
        push_cmd(1'b1, 32'd20, 3'd0, 4'b0000);
        vec_cnt++;
        if (bus_if.force_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL wr_req_early: force_req=%b want 0", bus_if.force_req);
        end
        tick();
        vec_cnt++;
        if ({bus_if.force_req, bus_if.rw, bus_if.contactAddress, bus_if.BE, bus_if.data}
            !== {1'b1, 1'b1, 32'd20, 4'h0, 32'd255}) begin
            err_cnt++;
            $display("FAIL wr_launch: req=%b rw=%b addr=%0d be=%h data=%0d want 1 1 20 0 255",
                     bus_if.force_req, bus_if.rw, bus_if.contactAddress, bus_if.BE, bus_if.data);
        end
        bus_if.grant = 1'b0;
        tick();
        bus_if.grant = 1'b1;
        bus_claim();
        tick();
        vec_cnt++;
        if ({bus_if.data, bus_if.done} !== {32'd255, 1'b0}) begin
            err_cnt++;
            $display("FAIL wr_beat_data: data=%0d done=%b want 255 0", bus_if.data, bus_if.done);
        end
        tick();
        vec_cnt++;
        if ({bus_if.done, bus_if.err, bus_if.force_req} !== 3'b100) begin
            err_cnt++;
            $display("FAIL wr_done: done=%b err=%b req=%b want 1 0 0", bus_if.done, bus_if.err, bus_if.force_req);
        end
        bus_idle();
        tick();
        vec_cnt++;
        if ({bus_if.done, bus_if.force_req} !== 2'b00) begin
            err_cnt++;
            $display("FAIL wr_after: done=%b req=%b want 0 0", bus_if.done, bus_if.force_req);
        end
    endtask

    task automatic test_burst_read;
        logic [31:0] vals [4];
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        push_cmd(1'b0, 32'd10, 3'd3, 4'hF);
        tick();
        vec_cnt++;
        if ({bus_if.force_req, bus_if.rw, bus_if.contactAddress, bus_if.BE} !== {1'b1, 1'b0, 32'd10, 4'hF}) begin
            err_cnt++;
            $display("FAIL rd_launch: req=%b rw=%b addr=%0d be=%h want 1 0 10 f",
                     bus_if.force_req, bus_if.rw, bus_if.contactAddress, bus_if.BE);
        end
        bus_if.grant = 1'b0;
        tick();
        bus_if.grant = 1'b1;
        bus_claim();
        bus_if.AD = vals[0];
        tick();
        vec_cnt++;
        if (bus_if.rd_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL rd_no_capture_on_claim: rd_valid=%b want 0", bus_if.rd_valid);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                bus_if.tready = 1'b1;
                tick();
                vec_cnt++;
                if ({bus_if.rd_valid, bus_if.done} !== 2'b00) begin
                    err_cnt++;
                    $display("FAIL rd_wait_state: rd_valid=%b done=%b want 0 0", bus_if.rd_valid, bus_if.done);
                end
                bus_if.tready = 1'b0;
            end
            bus_if.AD = vals[i];
            tick();
            vec_cnt++;
            if ({bus_if.rd_valid, bus_if.rd_data, bus_if.done} !== {1'b1, vals[i], (i == 3)}) begin
                err_cnt++;
                $display("FAIL rd_beat%0d: rd_valid=%b rd_data=%h done=%b want 1 %h %b",
                         i, bus_if.rd_valid, bus_if.rd_data, bus_if.done, vals[i], (i == 3));
            end
        end
        bus_idle();
        tick();
        vec_cnt++;
        if ({bus_if.rd_valid, bus_if.done, bus_if.force_req} !== 3'b000) begin
            err_cnt++;
            $display("FAIL rd_after: rd_valid=%b done=%b req=%b want 0 0 0",
                     bus_if.rd_valid, bus_if.done, bus_if.force_req);
        end
    endtask

    task automatic test_write_gating;
        logic [31:0] w [3];
        w = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222};
        push_wd(w[0]);
        push_wd(w[1]);
        push_cmd(1'b1, 32'h30, 3'd2, 4'hA);
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if (bus_if.force_req !== 1'b0) begin
                err_cnt++;
                $display("FAIL gate_hold%0d: force_req=%b want 0", i, bus_if.force_req);
            end
            tick();
        end
        push_wd(w[2]);
        vec_cnt++;
        if (bus_if.force_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL gate_push_edge: force_req=%b want 0", bus_if.force_req);
        end
        tick();
        vec_cnt++;
        if ({bus_if.force_req, bus_if.data, bus_if.contactAddress, bus_if.BE} !== {1'b1, w[0], 32'h30, 4'hA}) begin
            err_cnt++;
            $display("FAIL gate_launch: req=%b data=%h addr=%h be=%h want 1 %h 30 a",
                     bus_if.force_req, bus_if.data, bus_if.contactAddress, bus_if.BE, w[0]);
        end
        bus_if.grant = 1'b0;
        tick();
        bus_if.grant = 1'b1;
        bus_claim();
        tick();
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if ({bus_if.data, bus_if.done} !== {w[i], 1'b0}) begin
                err_cnt++;
                $display("FAIL gate_beat%0d: data=%h done=%b want %h 0", i, bus_if.data, bus_if.done, w[i]);
            end
            tick();
        end
        vec_cnt++;
        if ({bus_if.done, bus_if.err, bus_if.force_req} !== 3'b100) begin
            err_cnt++;
            $display("FAIL gate_done: done=%b err=%b req=%b want 1 0 0", bus_if.done, bus_if.err, bus_if.force_req);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_back_to_back;
        int cyc;
        bus_if.cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus_if.cmd_rw   = 1'b0;
            bus_if.cmd_addr = 32'h100 + 32'(k * 4);
            bus_if.cmd_len  = 3'd0;
            bus_if.cmd_be   = 4'hF;
            tick();
        end
        vec_cnt++;
        if (bus_if.cmd_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_full: cmd_ready=%b want 0", bus_if.cmd_ready);
        end
        bus_if.cmd_addr = 32'h999;
        tick();
        tick();
        vec_cnt++;
        if (bus_if.cmd_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_full_hold: cmd_ready=%b want 0", bus_if.cmd_ready);
        end
        bus_if.cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_req(cyc);
            vec_cnt++;
            if (cyc >= 20 || bus_if.contactAddress !== 32'h100 + 32'(k * 4)) begin
                err_cnt++;
                $display("FAIL b2b_cmd%0d_launch: waited=%0d addr=%h want <20 %h",
                         k, cyc, bus_if.contactAddress, 32'h100 + 32'(k * 4));
            end
            bus_if.grant = 1'b0;
            tick();
            bus_if.grant = 1'b1;
            bus_claim();
            bus_if.AD = 32'hC0 + 32'(k);
            tick();
            tick();
            vec_cnt++;
            if ({bus_if.done, bus_if.rd_valid, bus_if.rd_data, bus_if.force_req, bus_if.cmd_ready}
                !== {1'b1, 1'b1, 32'hC0 + 32'(k), 1'b0, 1'b1}) begin
                err_cnt++;
                $display("FAIL b2b_cmd%0d_done: done=%b rv=%b rd=%h req=%b rdy=%b want 1 1 %h 0 1",
                         k, bus_if.done, bus_if.rd_valid, bus_if.rd_data, bus_if.force_req, bus_if.cmd_ready,
                         32'hC0 + 32'(k));
            end
            bus_idle();
            tick();
            vec_cnt++;
            if (bus_if.force_req !== (k < 3)) begin
                err_cnt++;
                $display("FAIL b2b_gap%0d: force_req=%b want %b", k, bus_if.force_req, (k < 3));
            end
        end
        for (int i = 0; i < 3; i++) tick();
        vec_cnt++;
        if ({bus_if.force_req, bus_if.done} !== 2'b00) begin
            err_cnt++;
            $display("FAIL b2b_fifth_dropped: req=%b done=%b want 0 0", bus_if.force_req, bus_if.done);
        end
    endtask

    task automatic test_abort;
        int cyc;
        push_wd(32'hD0);
        push_wd(32'hD1);
        push_wd(32'hAB);
        push_cmd(1'b1, 32'h40, 3'd1, 4'h3);
        wait_req(cyc);
        vec_cnt++;
        if (cyc >= 20 || bus_if.data !== 32'hD0) begin
            err_cnt++;
            $display("FAIL abort_launch: waited=%0d data=%h want <20 d0", cyc, bus_if.data);
        end
        bus_if.grant = 1'b0;
        tick();
        bus_if.grant = 1'b1;
`ifdef PCI_SEQ_TIMEOUT_EN
        for (int i = 1; i <= 5; i++) begin
            tick();
            vec_cnt++;
            if ({bus_if.done, bus_if.force_req} !== 2'b01) begin
                err_cnt++;
                $display("FAIL abort_wait%0d: done=%b req=%b want 0 1", i, bus_if.done, bus_if.force_req);
            end
        end
        tick();
        vec_cnt++;
        if ({bus_if.done, bus_if.err, bus_if.force_req} !== 3'b110) begin
            err_cnt++;
            $display("FAIL abort_done: done=%b err=%b req=%b want 1 1 0", bus_if.done, bus_if.err, bus_if.force_req);
        end
`else
        for (int i = 1; i <= 10; i++) begin
            tick();
            vec_cnt++;
            if ({bus_if.done, bus_if.force_req} !== 2'b01) begin
                err_cnt++;
                $display("FAIL addr_wait%0d: done=%b req=%b want 0 1", i, bus_if.done, bus_if.force_req);
            end
        end
        bus_claim();
        tick();
        tick();
        tick();
        vec_cnt++;
        if ({bus_if.done, bus_if.err, bus_if.data} !== {1'b1, 1'b0, 32'hD1}) begin
            err_cnt++;
            $display("FAIL late_claim_done: done=%b err=%b data=%h want 1 0 d1", bus_if.done, bus_if.err, bus_if.data);
        end
`endif
        bus_idle();
        tick();
        push_cmd(1'b1, 32'h44, 3'd0, 4'hF);
        wait_req(cyc);
        vec_cnt++;
        if (cyc >= 20 || bus_if.data !== 32'hAB) begin
            err_cnt++;
            $display("FAIL abort_next_word: waited=%0d data=%h want <20 ab", cyc, bus_if.data);
        end
        bus_if.grant = 1'b0;
        tick();
        bus_if.grant = 1'b1;
        bus_claim();
        tick();
        tick();
        vec_cnt++;
        if ({bus_if.done, bus_if.err} !== 2'b10) begin
            err_cnt++;
            $display("FAIL abort_next_done: done=%b err=%b want 1 0", bus_if.done, bus_if.err);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_reset_mid_burst;
        int cyc;
        push_wd(32'h77);
        push_wd(32'h78);
        push_cmd(1'b0, 32'h50, 3'd7, 4'hF);
        wait_req(cyc);
        bus_if.grant = 1'b0;
        tick();
        bus_if.grant = 1'b1;
        bus_claim();
        bus_if.AD = 32'h5;
        tick();
        tick();
        tick();
        vec_cnt++;
        if ({bus_if.rd_valid, bus_if.force_req} !== 2'b11) begin
            err_cnt++;
            $display("FAIL rst_pre: rd_valid=%b req=%b want 1 1", bus_if.rd_valid, bus_if.force_req);
        end
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({bus_if.force_req, bus_if.cmd_ready, bus_if.wd_ready, bus_if.done, bus_if.rd_valid, bus_if.contactAddress}
            !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0}) begin
            err_cnt++;
            $display("FAIL rst_async: req=%b rdy=%b wrdy=%b done=%b rv=%b addr=%h want 0 1 1 0 0 0",
                     bus_if.force_req, bus_if.cmd_ready, bus_if.wd_ready, bus_if.done, bus_if.rd_valid,
                     bus_if.contactAddress);
        end
        bus_idle();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vec_cnt++;
            if ({bus_if.force_req, bus_if.done, bus_if.rd_valid} !== 3'b000) begin
                err_cnt++;
                $display("FAIL rst_cmd_empty%0d: req=%b done=%b rv=%b want 0 0 0",
                         i, bus_if.force_req, bus_if.done, bus_if.rd_valid);
            end
        end
        push_cmd(1'b1, 32'h60, 3'd0, 4'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            vec_cnt++;
            if (bus_if.force_req !== 1'b0) begin
                err_cnt++;
                $display("FAIL rst_wd_empty%0d: force_req=%b want 0", i, bus_if.force_req);
            end
        end
        push_wd(32'h5A);
        tick();
        vec_cnt++;
        if ({bus_if.force_req, bus_if.data, bus_if.contactAddress} !== {1'b1, 32'h5A, 32'h60}) begin
            err_cnt++;
            $display("FAIL rst_relaunch: req=%b data=%h addr=%h want 1 5a 60",
                     bus_if.force_req, bus_if.data, bus_if.contactAddress);
        end
        bus_if.grant = 1'b0;
        tick();
        bus_if.grant = 1'b1;
        bus_claim();
        tick();
        tick();
        vec_cnt++;
        if ({bus_if.done, bus_if.err, bus_if.force_req} !== 3'b100) begin
            err_cnt++;
            $display("FAIL rst_relaunch_done: done=%b err=%b req=%b want 1 0 0",
                     bus_if.done, bus_if.err, bus_if.force_req);
        end
        bus_idle();
        tick();
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_rw    = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_len   = '0;
        bus_if.cmd_be    = '0;
        bus_if.wd_valid  = 1'b0;
        bus_if.wd_data   = '0;
        bus_if.AD        = '0;
        bus_idle();
        test_reset();
        test_single_write();
        test_burst_read();
        test_write_gating();
        test_back_to_back();
        test_abort();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
        $fatal(1, "watchdog");
    end
endmodule
